axi_lite_bram_arbiter: RTL and testbench
========================================

// Module: axi_lite_bram_arbiter
// PURPOSE
//   Shares one single-port BRAM between NUM_REQ BRAM-style requesters, e.g. several AXI-lite BRAM
//   controllers or a DMA engine beside the CPU bus. Arbitration is round-robin with one access per
//   cycle. Each requester gets per-requester response tagging, timed to the BRAM read latency.
// PARAMETERS
//   NUM_REQ          2   number of requesters, 2..8
//   DATA_WIDTH       64  BRAM data width in bits, a multiple of 8
//   BRAM_ADDR_WIDTH  16  BRAM word-address width
//   READ_LATENCY     1   cycles from bram_en to valid bram_rddata, 1..3
// PORTS
//   clk          in   1                          clock, rising edge
//   rstn         in   1                          asynchronous active-low reset
//   req_valid    in   NUM_REQ                    per-requester access request
//   req_ready    out  NUM_REQ                    grant; the access is accepted when valid&&ready
//   req_we       in   NUM_REQ*DATA_WIDTH/8       byte write enables; all-zero means a read
//   req_addr     in   NUM_REQ*BRAM_ADDR_WIDTH    word address
//   req_wrdata   in   NUM_REQ*DATA_WIDTH         write data
//   rsp_valid    out  NUM_REQ                    response strobe, one pulse per accepted access
//   rsp_write    out  1                          the responding access was a write
//   rsp_rddata   out  DATA_WIDTH                 read data, shared by all requesters
//   req_lock     in   NUM_REQ                    hold grant (only with BRAM_ARB_LOCK_EN)
//   bram_en      out  1                          BRAM enable
//   bram_we      out  DATA_WIDTH/8               BRAM byte write enables
//   bram_addr    out  BRAM_ADDR_WIDTH            BRAM address
//   bram_wrdata  out  DATA_WIDTH                 BRAM write data
//   bram_rddata  in   DATA_WIDTH                 BRAM read data
// BEHAVIOUR
//   - One clock. Reset is asynchronous and active-low (clk, rstn).
//   - Reset values:
//     - rsp_valid=0, rsp_write=0, rsp_rddata=0.
//     - Priority pointer = requester 0.
//     - Response pipeline cleared.
//     - req_ready and bram_* are combinational and equal 0 while no request is valid.
//   - Grant: req_ready is one-hot or zero, a combinational function of req_valid and the pointer.
//     - Search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
//     - req_ready[i] is 0 whenever req_valid[i]=0.
//     - A requester must not drop req_valid or change its payload until accepted.
//   - Datapath: on accept, in the same cycle:
//     - bram_en=1.
//     - bram_we/bram_addr/bram_wrdata = the granted requester's fields.
//     - Otherwise bram_en=0 and bram_we=0.
//   - Pointer: after an accept from requester i, ptr <= (i+1) mod NUM_REQ. With no accept, ptr holds.
//   - Response pipeline: READ_LATENCY stages, each holding {valid, idx, write}. Stage 0 loads on accept.
//   - rsp_valid[idx] pulses exactly READ_LATENCY cycles after accept, for reads and for writes.
//     - rsp_write is the stored write flag.
//     - rsp_rddata = bram_rddata for reads and 0 for writes.
//     - There is no response backpressure; requesters must take the response in that cycle.
//   - Throughput: one access per cycle. Back-to-back responses to different requesters are allowed.
//   - Simultaneous requests: exactly one is granted; the losers keep valid and are served in RR order.
//   - Reset mid-operation drops in-flight responses; no rsp_valid pulse appears after rstn rises.
// CONFIGURATION
//   BRAM_ARB_LOCK_EN defined:
//     - The req_lock port exists.
//     - While the last accepted requester i holds req_lock[i]=1, only i can be granted; others wait.
//     - Lock is sampled on accept and held in a register until req_lock[i]=0.
//     - Use: atomic read-modify-write sequences.
//   BRAM_ARB_LOCK_EN undefined:
//     - The req_lock port is absent.
//     - Pure round-robin.
// STRUCTURE
//   Package bram_arb_pkg:
//     - req_idx_t: $clog2(NUM_REQ) bits, minimum 1.
//     - rsp_slot_t struct {valid, idx, write}.
//     - Function rr_pick(valid, ptr) returning a one-hot grant.
//   Sub-module bram_rr_arbiter:
//     - Owns the pointer register and grant logic (plus the lock register when enabled).
//     - The top level holds the datapath mux and the response pipeline.
// TESTING
//   - Reset: hold rstn=0 with all req_valid=1 -> req_ready=0, bram_en=0, rsp_valid=0.
//   - Single read: req0 reads addr 0x10 while the BRAM model returns 0xA5 (LAT=1).
//     -> bram_en=1, addr=0x10 in cycle t; rsp_valid=01, rsp_rddata=0xA5, rsp_write=0 at t+1.
//   - Contention: both requesters valid for 4 cycles from reset.
//     -> grants 0,1,0,1; rsp_valid 01,10,01,10, each one cycle later.
//   - Write: req1 we=0x0F, addr 3, data 0x1122334455667788.
//     -> bram_we=0x0F in the same cycle; rsp_valid=10, rsp_write=1, rsp_rddata=0 after READ_LATENCY.
//   - Latency: READ_LATENCY=3 with reads in consecutive cycles.
//     -> responses arrive 3 cycles later, in issue order, with no bubbles.
//   - Lock (BRAM_ARB_LOCK_EN): req0 locks across 3 accesses with req1 valid.
//     -> req1 is granted only after lock deasserts. Also: rstn pulse during in-flight reads
//        -> no stale rsp_valid.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and the round-robin pick function for the BRAM arbiter.
// Index types are sized for the largest supported requester count (8).
package bram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
    logic     write;
  } rsp_slot_t;

  // One-hot grant for the first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input req_idx_t           ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        j;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) begin
        j = j - n;
      end else begin
        j = j;
      end
      if ((k < n) && !found && valid[j[IDX_W-1:0]]) begin
        grant[j[IDX_W-1:0]] = 1'b1;
        found               = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bram_rr_arbiter.sv
// Round-robin grant logic and priority pointer for the shared BRAM port.
// With BRAM_ARB_LOCK_EN defined, a locking requester keeps the grant until it drops req_lock.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] req_lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic               accept,
  output req_idx_t           grant_idx
);

  req_idx_t           ptr_r;
  logic [MAX_REQ-1:0] valid_ext_s;
  logic [MAX_REQ-1:0] pick_s;
`ifdef BRAM_ARB_LOCK_EN
  logic               lock_active_r;
  req_idx_t           lock_idx_r;
  logic               locked_s;
  logic               lock_req_s;
`endif

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    valid_ext_s              = '0;
    valid_ext_s[NUM_REQ-1:0] = req_valid & {NUM_REQ{rstn}};
`ifdef BRAM_ARB_LOCK_EN
    locked_s   = 1'b0;
    lock_req_s = |(req_lock & grant);
    for (int k = 0; k < NUM_REQ; k++) begin
      locked_s = locked_s | (lock_active_r & req_lock[k] & (lock_idx_r == req_idx_t'(k)));
    end
    if (locked_s) begin
      pick_s = valid_ext_s & (8'd1 << lock_idx_r);
    end else begin
      pick_s = rr_pick(valid_ext_s, ptr_r, NUM_REQ);
    end
`else
    pick_s = rr_pick(valid_ext_s, ptr_r, NUM_REQ);
`endif
    grant     = pick_s[NUM_REQ-1:0];
    accept    = |pick_s;
    grant_idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      grant_idx = grant_idx | (req_idx_t'(k) & {IDX_W{pick_s[k]}});
    end
  end

  // Pointer moves to the requester after the one just served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= '0;
    end else if (accept) begin
      ptr_r <= (grant_idx == req_idx_t'(NUM_REQ - 1)) ? req_idx_t'(0) : grant_idx + req_idx_t'(1);
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  // Lock is captured on accept and released once the holder drops req_lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_active_r <= 1'b0;
      lock_idx_r    <= '0;
    end else if (accept) begin
      lock_active_r <= lock_req_s;
      lock_idx_r    <= grant_idx;
    end else if (!locked_s) begin
      lock_active_r <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/axi_lite_bram_arbiter.sv
// Shares one single-port BRAM between NUM_REQ requesters with round-robin arbitration and
// latency-matched response tagging. Optional grant locking via BRAM_ARB_LOCK_EN.
module axi_lite_bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int READ_LATENCY    = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_we,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wrdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                req_lock,
`endif
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic                              rsp_write,
  output logic [DATA_WIDTH-1:0]             rsp_rddata,
  output logic                              bram_en,
  output logic [DATA_WIDTH/8-1:0]           bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]             bram_wrdata,
  input  logic [DATA_WIDTH-1:0]             bram_rddata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  req_idx_t           grant_idx_s;
  rsp_slot_t          pipe_r [READ_LATENCY];
  rsp_slot_t          last_s;

  bram_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .grant     (grant_s),
    .accept    (accept_s),
    .grant_idx (grant_idx_s)
  );

  // Grant is one-hot, so an AND-OR mux selects the winning requester's fields.
  always_comb begin
    req_ready   = grant_s;
    bram_en     = accept_s;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bram_we     = bram_we     | (req_we[k*BE_W +: BE_W]                       & {BE_W{grant_s[k]}});
      bram_addr   = bram_addr   | (req_addr[k*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH] & {BRAM_ADDR_WIDTH{grant_s[k]}});
      bram_wrdata = bram_wrdata | (req_wrdata[k*DATA_WIDTH +: DATA_WIDTH]       & {DATA_WIDTH{grant_s[k]}});
    end
  end

  // Response tag pipeline, one stage per cycle of BRAM read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_r[s] <= '0;
      end
    end else begin
      pipe_r[0].valid <= accept_s;
      pipe_r[0].idx   <= grant_idx_s;
      pipe_r[0].write <= |bram_we;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_r[s] <= pipe_r[s-1];
      end
    end
  end

  // Last stage lines up with bram_rddata, so read data passes straight through.
  always_comb begin
    last_s     = pipe_r[READ_LATENCY-1];
    rsp_valid  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid[k] = last_s.valid & (last_s.idx == req_idx_t'(k));
    end
    rsp_write  = last_s.valid & last_s.write;
    rsp_rddata = (last_s.valid && !last_s.write) ? bram_rddata : '0;
  end

endmodule

// File: tb/tb_axi_lite_bram_arbiter.sv
// Directed self-checking bench: a READ_LATENCY=1 instance with a behavioural BRAM and a
// READ_LATENCY=3 instance with fixed read data. Lock steps run when BRAM_ARB_LOCK_EN is defined.
module tb_axi_lite_bram_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, req_ready, rsp_valid;
  logic [15:0]  req_we;
  logic [31:0]  req_addr;
  logic [127:0] req_wrdata;
  logic         rsp_write, bram_en;
  logic [63:0]  rsp_rddata, bram_wrdata, bram_rddata;
  logic [7:0]   bram_we;
  logic [15:0]  bram_addr;

  logic [1:0]   req_valid3, req_ready3, rsp_valid3;
  logic [15:0]  req_we3;
  logic [31:0]  req_addr3;
  logic [127:0] req_wrdata3;
  logic         rsp_write3, bram_en3;
  logic [63:0]  rsp_rddata3, bram_wrdata3, bram_rddata3;
  logic [7:0]   bram_we3;
  logic [15:0]  bram_addr3;
`ifdef BRAM_ARB_LOCK_EN
  logic [1:0]   req_lock  = 2'b00;
  logic [1:0]   req_lock3 = 2'b00;
`endif

  logic [63:0] mem [0:31];
  logic [63:0] rd_q = 64'h0;
  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_bram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(64), .BRAM_ADDR_WIDTH(16), .READ_LATENCY(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wrdata(req_wrdata),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rddata(rsp_rddata), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  axi_lite_bram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(64), .BRAM_ADDR_WIDTH(16), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wrdata(req_wrdata3),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock(req_lock3),
`endif
    .rsp_valid(rsp_valid3), .rsp_write(rsp_write3), .rsp_rddata(rsp_rddata3), .bram_en(bram_en3),
    .bram_we(bram_we3), .bram_addr(bram_addr3), .bram_wrdata(bram_wrdata3), .bram_rddata(bram_rddata3)
  );

  // Read-first single-port BRAM with byte enables and one cycle of read latency.
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bram_we[b]) mem[bram_addr[4:0]][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      end
      rd_q <= mem[bram_addr[4:0]];
    end
  end
  assign bram_rddata = rd_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_v;
    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
    mem[1]  = 64'h1111;
    mem[2]  = 64'h2222;
    mem[16] = 64'hA5;
    req_valid = 2'b11; req_we = 16'h0; req_addr = 32'h0; req_wrdata = 128'h0;
    req_valid3 = 2'b11; req_we3 = 16'h0; req_addr3 = 32'h0; req_wrdata3 = 128'h0;
    bram_rddata3 = 64'hC0DE;

    // Reset with all requests valid
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready",      64'(req_ready),  64'h0);
    check("reset_bram_en",    64'(bram_en),    64'h0);
    check("reset_rsp_valid",  64'(rsp_valid),  64'h0);
    check("reset_rsp_write",  64'(rsp_write),  64'h0);
    check("reset_rsp_rddata", rsp_rddata,      64'h0);
    check("reset_ready3",     64'(req_ready3), 64'h0);
    req_valid = 2'b00; req_valid3 = 2'b00;
    @(negedge clk); rstn = 1'b1;

    // Single read by requester 0
    @(negedge clk); req_valid = 2'b01; req_addr = {16'h0, 16'h10};
    #1;
    check("rd_ready",   64'(req_ready), 64'h1);
    check("rd_bram_en", 64'(bram_en),   64'h1);
    check("rd_addr",    64'(bram_addr), 64'h10);
    check("rd_we",      64'(bram_we),   64'h0);
    @(negedge clk); req_valid = 2'b00;
    #1;
    check("rd_rsp_valid",  64'(rsp_valid), 64'h1);
    check("rd_rsp_rddata", rsp_rddata,     64'hA5);
    check("rd_rsp_write",  64'(rsp_write), 64'h0);
    check("idle_bram_en",  64'(bram_en),   64'h0);

    // Reset pulse returns the pointer to requester 0
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // Contention: both valid for four cycles
    req_addr = {16'h2, 16'h1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); req_valid = 2'b11;
      #1;
      check("cont_grant", 64'(req_ready), (c % 2 == 1) ? 64'h2 : 64'h1);
      check("cont_rsp",   64'(rsp_valid), (c == 0) ? 64'h0 : ((c % 2 == 1) ? 64'h1 : 64'h2));
      if (c > 0) check("cont_data", rsp_rddata, (c % 2 == 1) ? 64'h1111 : 64'h2222);
    end
    @(negedge clk); req_valid = 2'b00;
    #1;
    check("cont_last_rsp",  64'(rsp_valid), 64'h2);
    check("cont_last_data", rsp_rddata,     64'h2222);

    // Byte-masked write by requester 1, then read back through requester 0
    @(negedge clk);
    req_valid = 2'b10; req_we = {8'h0F, 8'h00}; req_addr = {16'h3, 16'h0};
    req_wrdata = {64'h1122334455667788, 64'h0};
    #1;
    check("wr_ready", 64'(req_ready), 64'h2);
    check("wr_we",    64'(bram_we),   64'h0F);
    check("wr_addr",  64'(bram_addr), 64'h3);
    check("wr_data",  bram_wrdata,    64'h1122334455667788);
    @(negedge clk);
    req_valid = 2'b01; req_we = 16'h0; req_addr = {16'h0, 16'h3};
    #1;
    check("wr_rsp_valid",  64'(rsp_valid), 64'h2);
    check("wr_rsp_write",  64'(rsp_write), 64'h1);
    check("wr_rsp_rddata", rsp_rddata,     64'h0);
    check("rb_ready",      64'(req_ready), 64'h1);
    @(negedge clk); req_valid = 2'b00;
    #1;
    check("rb_rsp_valid", 64'(rsp_valid), 64'h1);
    check("rb_rsp_data",  rsp_rddata,     64'h0000000055667788);
    check("rb_rsp_write", 64'(rsp_write), 64'h0);

    // READ_LATENCY=3: three back-to-back reads, responses three cycles later
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); req_valid3 = (c < 3) ? 2'b11 : 2'b00;
      #1;
      exp_v = (c == 3 || c == 5) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
      check("lat_bram_en", 64'(bram_en3),   (c < 3) ? 64'h1 : 64'h0);
      check("lat_rsp",     64'(rsp_valid3), 64'(exp_v));
      check("lat_data",    rsp_rddata3,     (exp_v != 2'b00) ? 64'hC0DE : 64'h0);
    end

    // Reset while reads are in flight drops their responses
    @(negedge clk); req_valid3 = 2'b11;
    @(negedge clk); req_valid3 = 2'b11;
    @(negedge clk); req_valid3 = 2'b00; rstn = 1'b0;
    #1;
    check("mf_in_reset", 64'(rsp_valid3), 64'h0);
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("mf_post_rsp", 64'(rsp_valid3), 64'h0);
    end

`ifdef BRAM_ARB_LOCK_EN
    // Requester 0 holds the lock for three accesses while requester 1 waits
    req_addr = {16'h2, 16'h1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); req_valid = 2'b11; req_lock = (c < 3) ? 2'b01 : 2'b00;
      #1;
      check("lock_grant", 64'(req_ready), (c < 3) ? 64'h1 : 64'h2);
    end
    @(negedge clk); req_valid = 2'b00; req_lock = 2'b00;
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
